// File: rtl/regdst_pkg.sv
// Shared definitions for the register-destination select and tracking pipeline.
package regdst_pkg;

    // Destination source encoding driven by the decoder.
    typedef enum logic [1:0] {
        REGDST_RT   = 2'd0,
        REGDST_RD   = 2'd1,
        REGDST_LINK = 2'd2,
        REGDST_NONE = 2'd3
    } regdst_e;

    // Stage record layout, MSB first: {valid, wr, dest[addr_w-1:0]}.
    localparam int unsigned STAGE_CTRL_BITS = 2;

    function automatic int unsigned stage_width(input int unsigned addr_w);
        return addr_w + STAGE_CTRL_BITS;
    endfunction

endpackage

// File: rtl/regdst_stage.sv
// One destination-tracking stage register: reset/bubble clear, load captures, else hold.
module regdst_stage
    import regdst_pkg::*;
#(
    parameter int unsigned WIDTH = 7
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] rec_q;

    // A bubble clears dest too, so a dead slot always reads back as index 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rec_q <= '0;
        end else if (bubble) begin
            rec_q <= '0;
        end else if (load) begin
            rec_q <= d;
        end
    end

    assign q = rec_q;

endmodule

// File: rtl/regdst_pipe.sv
// Write-register selector plus DEPTH-stage destination pipeline with hazard reporting.
module regdst_pipe
    import regdst_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LINK_REG   = 31
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  InValid,
    input  logic                  RegWrite_in,
    input  logic [1:0]            RegDst,
    input  logic [REG_ADDR_W-1:0] Rt,
    input  logic [REG_ADDR_W-1:0] Rd,
    input  logic [REG_ADDR_W-1:0] SrcA,
    input  logic [REG_ADDR_W-1:0] SrcB,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic                  RegWrite,
    output logic                  HazardA,
    output logic                  HazardB
);

    localparam int unsigned SW      = stage_width(REG_ADDR_W);
    localparam int unsigned VALID_B = SW - 1;
    localparam int unsigned WR_B    = SW - 2;

    logic [REG_ADDR_W-1:0]   sel_dest;
    logic                    eff_wr;
    logic [SW-1:0]           new_entry;
    logic [DEPTH-1:0][SW-1:0] stage_q;
    logic                    hazard_a;
    logic                    hazard_b;

    // Decode-time destination select.
    always_comb begin
        sel_dest = '0;
        unique case (regdst_e'(RegDst))
            REGDST_RT:   sel_dest = Rt;
            REGDST_RD:   sel_dest = Rd;
            REGDST_LINK: sel_dest = REG_ADDR_W'(LINK_REG);
            REGDST_NONE: sel_dest = '0;
            default:     sel_dest = '0;
        endcase
    end

    // Writes to $0 are architecturally void, so they are never tracked as pending.
    assign eff_wr = InValid & RegWrite_in & (RegDst != REGDST_NONE) & (sel_dest != '0);

    // Empty decode slots enter as clean bubbles.
    assign new_entry = InValid ? {1'b1, eff_wr, sel_dest} : '0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [SW-1:0] stage_d;
        logic          stage_ld;
        logic          stage_bub;

        if (k == 0) begin : g_head
            // Flush beats Stall: the slot is killed rather than held.
            assign stage_d   = new_entry;
            assign stage_ld  = ~Stall;
            assign stage_bub = Flush;
        end else if (k == 1) begin : g_second
            // A stall opens a gap behind the held head; a flush lets the head drain instead.
            assign stage_d   = stage_q[0];
            assign stage_ld  = 1'b1;
            assign stage_bub = Stall & ~Flush;
        end else begin : g_tail
            assign stage_d   = stage_q[k-1];
            assign stage_ld  = 1'b1;
            assign stage_bub = 1'b0;
        end

        regdst_stage #(
            .WIDTH (SW)
        ) u_stage (
            .Clk    (Clk),
            .Reset  (Reset),
            .load   (stage_ld),
            .bubble (stage_bub),
            .d      (stage_d),
            .q      (stage_q[k])
        );
    end

    // Pending-write compare over all stages but the last, which writes in the first half-cycle.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int unsigned k = 0; k < DEPTH - 1; k++) begin
            if (stage_q[k][VALID_B] && stage_q[k][WR_B]) begin
                if (stage_q[k][REG_ADDR_W-1:0] == SrcA) hazard_a = 1'b1;
                if (stage_q[k][REG_ADDR_W-1:0] == SrcB) hazard_b = 1'b1;
            end
        end
        if (SrcA == '0) hazard_a = 1'b0;
        if (SrcB == '0) hazard_b = 1'b0;
    end

    assign HazardA  = hazard_a;
    assign HazardB  = hazard_b;
    assign WriteReg = stage_q[DEPTH-1][REG_ADDR_W-1:0];
    assign RegWrite = stage_q[DEPTH-1][VALID_B] & stage_q[DEPTH-1][WR_B];

endmodule
